// File: rtl/jtag_sram_cmd_ctrl.sv
// Executes JTAG update-DR commands (address load, SRAM write, SRAM read) in the clk domain.
// Optional address auto-increment after each write/read: define JTAG_SRAM_AUTOINC_EN.
module jtag_sram_cmd_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              udr,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] dr_data,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_we,
    output logic              sram_re,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RWAIT} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic              s1, s2, s3;
    logic              start, accept, err_set, capture;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // udr is asynchronous: two-flop synchronizer, then rising-edge detect on s2.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= udr;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start   = s2 & ~s3;
    assign busy    = (state != IDLE);
    assign accept  = start & ~busy;
    assign err_set = start & (busy | (cmd == 2'b11));
    assign capture = (state == RWAIT) && (cnt == 2'd0);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && cmd == 2'b01)      state_nxt = WRITE;
                else if (accept && cmd == 2'b10) state_nxt = READ;
            end
            WRITE:   state_nxt = IDLE;
            READ:    state_nxt = RWAIT;
            RWAIT:   if (cnt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sram_we    = (state == WRITE);
    assign sram_re    = (state == READ);
    assign sram_addr  = addr_q;
    assign sram_wdata = data_q;

    // rd_valid is registered so it rises together with the new rd_data value.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            addr_q   <= '0;
            data_q   <= '0;
            cnt      <= 2'd0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) data_q <= dr_data;

            if (accept && cmd == 2'b00) addr_q <= dr_addr;
`ifdef JTAG_SRAM_AUTOINC_EN
            else if (state == WRITE || capture) addr_q <= addr_q + 1'b1;
`endif

            if (state == READ)                     cnt <= LAT_LOAD;
            else if (state == RWAIT && cnt != 2'd0) cnt <= cnt - 1'b1;

            rd_valid <= capture;
            if (capture) rd_data <= sram_rdata;

            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule
